// File: rtl/bk_mem_arbiter.sv
// Multi-port SRAM arbiter with a guaranteed two-clock video fetch at the start of every slot.
// Define MEM_ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest port index wins.
module bk_mem_arbiter #(
  parameter int NPORTS       = 3,
  parameter int AW           = 18,
  parameter int DW           = 16,
  parameter int VSLOT_PERIOD = 16
) (
  input  logic                 clk25,
  input  logic                 reset_in,
  input  logic [NPORTS-1:0]    req_i,
  input  logic [NPORTS-1:0]    we_i,
  input  logic [2*NPORTS-1:0]  be_i,
  input  logic [NPORTS*AW-1:0] addr_i,
  input  logic [NPORTS*DW-1:0] wdata_i,
  output logic [NPORTS-1:0]    ack_o,
  output logic [DW-1:0]        rdata_o,
  input  logic [AW-1:0]        vid_addr_i,
  output logic [DW-1:0]        vid_data_o,
  output logic                 vid_valid_o,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_dq_o,
  output logic                 ram_dq_oe,
  input  logic [DW-1:0]        ram_dq_i,
  output logic                 ram_we_n,
  output logic                 ram_oe_n,
  output logic                 ram_lb_n,
  output logic                 ram_ub_n
);

  localparam int CW = $clog2(VSLOT_PERIOD);
  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(VSLOT_PERIOD - 1);
  localparam logic [CW-1:0] ARB_LO    = CW'(2);
  localparam logic [CW-1:0] ARB_HI    = CW'(VSLOT_PERIOD - 3);

  typedef enum logic [1:0] {IDLE, VID, ACC1, ACC2} state_t;

  state_t              r_state, w_nextState;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_port;
  logic                r_we;
  logic [1:0]          r_be;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic [AW-1:0]       r_addrHold;
  logic [NPORTS-1:0]   r_ack;
  logic [DW-1:0]       r_rdata;
  logic [DW-1:0]       r_vidData;
  logic                r_vidValid;

  logic [NPORTS-1:0]   w_reqMasked;
  logic [IW-1:0]       w_base;
  logic [IW-1:0]       w_scanIdx;
  logic [IW-1:0]       w_grantIdx;
  logic                w_grantValid;
  logic                w_grant;
  logic [AW-1:0]       w_ramAddr;
  logic                w_weN, w_oeN, w_lbN, w_ubN, w_dqOe;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0]       r_rrPtr;

  // Priority starts just after the most recently granted port.
  always_ff @(posedge clk25) begin
    if (reset_in)
      r_rrPtr <= '0;
    else if (w_grant)
      r_rrPtr <= (int'(w_grantIdx) == NPORTS - 1) ? '0 : w_grantIdx + IW'(1);
  end

  assign w_base = r_rrPtr;
`else
  assign w_base = '0;
`endif

  // A port being acked this cycle must not be re-granted off its stale request.
  always_comb begin
    w_reqMasked  = req_i & ~r_ack;
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_scanIdx    = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_scanIdx = IW'((int'(w_base) + i) % NPORTS);
      if (!w_grantValid && w_reqMasked[w_scanIdx]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = w_scanIdx;
      end
    end
  end

  // Grants stop at VSLOT_PERIOD-3 so ACC2 always ends before the next video fetch.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_cnt == SLOT_LAST)
          w_nextState = VID;
        else if (r_cnt >= ARB_LO && r_cnt <= ARB_HI && w_grantValid) begin
          w_nextState = ACC1;
          w_grant     = 1'b1;
        end
      end
      VID:     if (r_cnt == CW'(1)) w_nextState = IDLE;
      ACC1:    w_nextState = ACC2;
      ACC2:    w_nextState = (r_cnt == SLOT_LAST) ? VID : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_ramAddr = r_addrHold;
    w_weN     = 1'b1;
    w_oeN     = 1'b1;
    w_lbN     = 1'b1;
    w_ubN     = 1'b1;
    w_dqOe    = 1'b0;
    case (r_state)
      VID: begin
        w_ramAddr = vid_addr_i;
        w_oeN     = 1'b0;
        w_lbN     = 1'b0;
        w_ubN     = 1'b0;
      end
      ACC1, ACC2: begin
        w_ramAddr = r_addr;
        w_lbN     = ~r_be[0];
        w_ubN     = ~r_be[1];
        if (r_we) begin
          w_dqOe = 1'b1;
          w_weN  = (r_state != ACC1);
        end else begin
          w_oeN  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (reset_in) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_port     <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_addrHold <= '0;
      r_ack      <= '0;
      r_rdata    <= '0;
      r_vidData  <= '0;
      r_vidValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= r_cnt + CW'(1);
      r_addrHold <= w_ramAddr;
      r_ack      <= '0;
      r_vidValid <= (r_state == VID) && (r_cnt == CW'(1));
      if (r_state == VID && r_cnt == CW'(1))
        r_vidData <= ram_dq_i;
      if (r_state == ACC2) begin
        r_ack[r_port] <= 1'b1;
        if (!r_we)
          r_rdata <= ram_dq_i;
      end
      if (w_grant) begin
        r_port  <= w_grantIdx;
        r_we    <= we_i[w_grantIdx];
        r_be    <= be_i[int'(w_grantIdx)*2 +: 2];
        r_addr  <= addr_i[int'(w_grantIdx)*AW +: AW];
        r_wdata <= wdata_i[int'(w_grantIdx)*DW +: DW];
      end
    end
  end

  assign ack_o       = r_ack;
  assign rdata_o     = r_rdata;
  assign vid_data_o  = r_vidData;
  assign vid_valid_o = r_vidValid;
  assign ram_addr    = w_ramAddr;
  assign ram_dq_o    = r_wdata;
  assign ram_dq_oe   = w_dqOe;
  assign ram_we_n    = w_weN;
  assign ram_oe_n    = w_oeN;
  assign ram_lb_n    = w_lbN;
  assign ram_ub_n    = w_ubN;

endmodule

// File: tb/tb_bk_mem_arbiter.sv
// Self-checking bench for bk_mem_arbiter: directed slot-timing scenarios followed by random
// single-port traffic checked against a slot-arithmetic latency model and a shadow memory.
module tb_bk_mem_arbiter;

  localparam int NP = 3;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int SLOT = 16;
  localparam logic [AW-1:0] VID_ADDR = 18'h04000;
  localparam logic [AW-1:0] WIN_BASE = 18'h02000;

  logic             clk25 = 1'b0;
  logic             reset_in;
  logic [NP-1:0]    req_i, we_i;
  logic [2*NP-1:0]  be_i;
  logic [NP*AW-1:0] addr_i;
  logic [NP*DW-1:0] wdata_i;
  logic [NP-1:0]    ack_o;
  logic [DW-1:0]    rdata_o;
  logic [AW-1:0]    vid_addr_i;
  logic [DW-1:0]    vid_data_o;
  logic             vid_valid_o;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_dq_o;
  logic             ram_dq_oe;
  logic [DW-1:0]    ram_dq_i;
  logic             ram_we_n, ram_oe_n, ram_lb_n, ram_ub_n;

  logic [DW-1:0]    sram [0:(1<<AW)-1];
  logic             plEn;
  logic [AW-1:0]    plAddr;
  logic [DW-1:0]    plData;
  logic [DW-1:0]    refMem [0:15];

  int cycleNo;
  int checks = 0;
  int failures = 0;

  bk_mem_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .VSLOT_PERIOD(SLOT)) dut (
    .clk25(clk25), .reset_in(reset_in), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .vid_addr_i(vid_addr_i), .vid_data_o(vid_data_o), .vid_valid_o(vid_valid_o),
    .ram_addr(ram_addr), .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe), .ram_dq_i(ram_dq_i),
    .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n), .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n)
  );

  always #5 clk25 = ~clk25;

  // Asynchronous SRAM: reads follow the address, writes land on the clock edge per byte lane.
  assign ram_dq_i = sram[ram_addr];

  always @(posedge clk25) begin
    if (plEn)
      sram[plAddr] <= plData;
    else if (!ram_we_n) begin
      if (!ram_lb_n) sram[ram_addr][7:0]  <= ram_dq_o[7:0];
      if (!ram_ub_n) sram[ram_addr][15:8] <= ram_dq_o[15:8];
    end
  end

  // Clocks since the last reset; modulo SLOT it is the slot position the design should be at.
  always @(posedge clk25) begin
    if (reset_in) cycleNo <= 0;
    else          cycleNo <= cycleNo + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int p, input logic r, input logic w, input logic [1:0] b,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_i[p]            = r;
    we_i[p]             = w;
    be_i[p*2 +: 2]      = b;
    addr_i[p*AW +: AW]  = a;
    wdata_i[p*DW +: DW] = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    plAddr = a;
    plData = d;
    plEn   = 1'b1;
    @(negedge clk25);
    plEn   = 1'b0;
  endtask

  task automatic waitSlot(input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk25);
      n++;
    end while ((cycleNo % SLOT) != v && n < 64);
    if ((cycleNo % SLOT) != v) begin
      checks++;
      failures++;
      $display("[TB] FAIL waitSlot observed=%0d expected=%0d", cycleNo % SLOT, v);
    end
  endtask

  initial begin
    int ordr [3];
    int ackAt [3];
    logic [DW-1:0] portData [3];
    logic sawAck;
    int prevPort, prevAck;

    reset_in   = 1'b1;
    req_i      = '0;
    we_i       = '0;
    be_i       = '0;
    addr_i     = '0;
    wdata_i    = '0;
    vid_addr_i = VID_ADDR;
    plEn       = 1'b0;
    plAddr     = '0;
    plData     = '0;

    $display("[TB] reset state");
    @(negedge clk25);
    @(negedge clk25);
    checkOutput("rst_ack", 32'(ack_o), 0);
    checkOutput("rst_vid_valid", 32'(vid_valid_o), 0);
    checkOutput("rst_rdata", 32'(rdata_o), 0);
    checkOutput("rst_vid_data", 32'(vid_data_o), 0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 0);
    checkOutput("rst_we_n", 32'(ram_we_n), 1);
    checkOutput("rst_oe_n", 32'(ram_oe_n), 1);
    checkOutput("rst_lb_n", 32'(ram_lb_n), 1);
    checkOutput("rst_ub_n", 32'(ram_ub_n), 1);
    checkOutput("rst_dq_oe", 32'(ram_dq_oe), 0);

    preload(18'h01234, 16'hBEEF);
    preload(VID_ADDR, 16'h5A5A);
    preload(18'h00100, 16'h0011);
    preload(18'h00010, 16'h7777);
    for (int i = 0; i < 16; i++) begin
      refMem[i] = 16'($urandom);
      preload(WIN_BASE + AW'(i), refMem[i]);
    end
    reset_in = 1'b0;

    $display("[TB] video guard");
    waitSlot(14);
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 18'h00010, 16'h0);
    waitSlot(15);
    checkOutput("guard_15_oe_n", 32'(ram_oe_n), 1);
    waitSlot(0);
    checkOutput("guard_vid0_addr", 32'(ram_addr), 32'(VID_ADDR));
    checkOutput("guard_vid0_oe_n", 32'(ram_oe_n), 0);
    waitSlot(1);
    checkOutput("guard_vid1_lanes", 32'({ram_ub_n, ram_lb_n}), 0);
    waitSlot(2);
    checkOutput("vid_valid_a", 32'(vid_valid_o), 1);
    checkOutput("vid_data_a", 32'(vid_data_o), 32'h5A5A);
    waitSlot(3);
    checkOutput("guard_acc1_addr", 32'(ram_addr), 32'h00010);
    checkOutput("vid_valid_pulse", 32'(vid_valid_o), 0);
    waitSlot(5);
    checkOutput("guard_ack", 32'(ack_o), 32'b001);
    checkOutput("guard_rdata", 32'(rdata_o), 32'h7777);
    applyStimulus(0, 1'b0, 1'b0, 2'b00, 18'h0, 16'h0);

    $display("[TB] single read");
    waitSlot(2);
    checkOutput("vid_valid_b", 32'(vid_valid_o), 1);
    applyStimulus(1, 1'b1, 1'b0, 2'b11, 18'h01234, 16'h0);
    waitSlot(3);
    checkOutput("rd_acc1_addr", 32'(ram_addr), 32'h01234);
    checkOutput("rd_acc1_oe_n", 32'(ram_oe_n), 0);
    waitSlot(4);
    checkOutput("rd_acc2_ack", 32'(ack_o), 0);
    waitSlot(5);
    checkOutput("rd_ack", 32'(ack_o), 32'b010);
    checkOutput("rd_rdata", 32'(rdata_o), 32'hBEEF);
    applyStimulus(1, 1'b0, 1'b0, 2'b00, 18'h0, 16'h0);
    waitSlot(6);
    checkOutput("rd_ack_pulse", 32'(ack_o), 0);

    $display("[TB] contention");
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ordr = '{2, 0, 1};
`else
    ordr = '{0, 1, 2};
`endif
    ackAt    = '{5, 8, 11};
    portData = '{16'hBEEF, 16'h7777, 16'h5A5A};
    waitSlot(2);
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 18'h01234, 16'h0);
    applyStimulus(1, 1'b1, 1'b0, 2'b11, 18'h00010, 16'h0);
    applyStimulus(2, 1'b1, 1'b0, 2'b11, VID_ADDR, 16'h0);
    for (int k = 0; k < 3; k++) begin
      waitSlot(ackAt[k]);
      checkOutput($sformatf("cont_ack_%0d", k), 32'(ack_o), 32'(1) << ordr[k]);
      checkOutput($sformatf("cont_rdata_%0d", k), 32'(rdata_o), 32'(portData[ordr[k]]));
      applyStimulus(ordr[k], 1'b0, 1'b0, 2'b00, 18'h0, 16'h0);
    end

    $display("[TB] byte write");
    waitSlot(2);
    applyStimulus(2, 1'b1, 1'b1, 2'b10, 18'h00100, 16'hA500);
    waitSlot(3);
    checkOutput("bw_acc1_we_n", 32'(ram_we_n), 0);
    checkOutput("bw_acc1_lanes", 32'({ram_ub_n, ram_lb_n}), 32'b01);
    checkOutput("bw_acc1_dq", 32'(ram_dq_o), 32'hA500);
    checkOutput("bw_acc1_dq_oe", 32'(ram_dq_oe), 1);
    waitSlot(4);
    checkOutput("bw_acc2_we_n", 32'(ram_we_n), 1);
    checkOutput("bw_acc2_dq_oe", 32'(ram_dq_oe), 1);
    waitSlot(5);
    checkOutput("bw_ack", 32'(ack_o), 32'b100);
    applyStimulus(2, 1'b0, 1'b0, 2'b00, 18'h0, 16'h0);
    waitSlot(6);
    applyStimulus(0, 1'b1, 1'b0, 2'b11, 18'h00100, 16'h0);
    waitSlot(9);
    checkOutput("bw_readback_ack", 32'(ack_o), 32'b001);
    checkOutput("bw_readback", 32'(rdata_o), 32'hA511);
    applyStimulus(0, 1'b0, 1'b0, 2'b00, 18'h0, 16'h0);

    $display("[TB] reset during write");
    waitSlot(2);
    applyStimulus(0, 1'b1, 1'b1, 2'b11, 18'h00200, 16'h1234);
    waitSlot(3);
    checkOutput("ra_acc1_we_n", 32'(ram_we_n), 0);
    reset_in = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 2'b00, 18'h0, 16'h0);
    @(negedge clk25);
    checkOutput("ra_we_n", 32'(ram_we_n), 1);
    checkOutput("ra_dq_oe", 32'(ram_dq_oe), 0);
    checkOutput("ra_ack", 32'(ack_o), 0);
    reset_in = 1'b0;
    sawAck = 1'b0;
    repeat (6) begin
      @(negedge clk25);
      sawAck = sawAck | (|ack_o);
    end
    checkOutput("ra_no_late_ack", 32'(sawAck), 0);

    $display("[TB] random traffic");
    prevPort = -1;
    prevAck  = -1;
    for (int it = 0; it < 24; it++) begin
      int p, off, r, g, expAck, n;
      logic w;
      logic [1:0] b;
      logic [DW-1:0] d;
      p   = $urandom_range(0, NP - 1);
      w   = 1'($urandom_range(0, 1));
      b   = 2'($urandom_range(0, 3));
      off = $urandom_range(0, 15);
      d   = 16'($urandom);
      repeat ($urandom_range(0, 17)) @(negedge clk25);
      r = cycleNo;
      if (p == prevPort && r == prevAck) r = r + 1;
      g = r;
      while ((g % SLOT) < 2 || (g % SLOT) > SLOT - 3) g++;
      expAck = g + 3;
      applyStimulus(p, 1'b1, w, b, WIN_BASE + AW'(off), d);
      n = 0;
      do begin
        @(negedge clk25);
        n++;
      end while (ack_o == '0 && n < 40);
      checkOutput($sformatf("rnd%0d_latency", it), 32'(cycleNo), 32'(expAck));
      checkOutput($sformatf("rnd%0d_ack", it), 32'(ack_o), 32'(1) << p);
      if (!w)
        checkOutput($sformatf("rnd%0d_rdata", it), 32'(rdata_o), 32'(refMem[off]));
      else begin
        if (b[0]) refMem[off][7:0]  = d[7:0];
        if (b[1]) refMem[off][15:8] = d[15:8];
      end
      applyStimulus(p, 1'b0, 1'b0, 2'b00, 18'h0, 16'h0);
      prevPort = p;
      prevAck  = cycleNo;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bk_mem_arbiter.md
BK_MEM_ARBITER -- requirements
Module: bk_mem_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 3: number of requester ports; legal range 1..8.
REQ-002 SHALL have parameter AW, default 18: SRAM word-address width.
REQ-003 SHALL have parameter DW, default 16: SRAM data width; byte lanes fixed at 2.
REQ-004 SHALL have parameter VSLOT_PERIOD, default 16: clocks per video slot; power of 2, at least 8.
REQ-005 SHALL have port `clk25`, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-006 SHALL have port `reset_in`, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port `req_i`, input, NPORTS bits: per-port access request, level.
REQ-008 SHALL have port `we_i`, input, NPORTS bits: per-port 1=write, 0=read.
REQ-009 SHALL have port `be_i`, input, 2*NPORTS bits: per-port byte enables, active-high; bit1 = upper lane.
REQ-010 SHALL have port `addr_i`, input, NPORTS*AW bits: per-port word address.
REQ-011 SHALL have port `wdata_i`, input, NPORTS*DW bits: per-port write data.
REQ-012 SHALL have port `ack_o`, output, NPORTS bits: one-cycle completion pulse per port.
REQ-013 SHALL have port `rdata_o`, output, DW bits: read data; valid while the matching ack_o bit is high.
REQ-014 SHALL have port `vid_addr_i`, input, AW bits: video fetch address.
REQ-015 SHALL have port `vid_data_o`, output, DW bits: fetched video word.
REQ-016 SHALL have port `vid_valid_o`, output, 1 bit: one-cycle pulse qualifying vid_data_o.
REQ-017 SHALL have SRAM-side ports:
- `ram_addr`, output, AW bits.
- `ram_dq_o`, output, DW bits.
- `ram_dq_oe`, output, 1 bit.
- `ram_dq_i`, input, DW bits.
- `ram_we_n`, `ram_oe_n`, `ram_lb_n`, `ram_ub_n`, output, 1 bit each, active-low.

Function
REQ-018 SHALL run a free-running slot counter, modulo VSLOT_PERIOD, incremented every clock.
REQ-019 SHALL use four registered states: IDLE, VID, ACC1, ACC2.
REQ-020 SHALL enter VID when the counter is 0 and stay in VID for counter values 0 and 1.
- ram_addr = vid_addr_i; ram_oe_n = 0; both lanes low.
REQ-021 SHALL capture ram_dq_i into vid_data_o at the end of counter value 1 and pulse vid_valid_o at counter value 2.
REQ-022 SHALL arbitrate only in IDLE with counter in [2, VSLOT_PERIOD-3], so that no access overlaps VID.
REQ-023 SHALL, on grant, latch the port index, we, be, addr and wdata; the transaction then completes even if req_i drops.
REQ-024 SHALL drive ram_addr with the latched address during ACC1 (grant+1) and ACC2 (grant+2).
REQ-025 SHALL, for a read, hold ram_oe_n=0 through ACC1 and ACC2 and capture ram_dq_i into rdata_o at the end of ACC2.
REQ-026 SHALL, for a write, hold ram_dq_oe=1 with ram_dq_o = data through ACC1 and ACC2, and assert ram_we_n=0 in ACC1 only.
REQ-027 SHALL drive ram_lb_n = ~be[0] and ram_ub_n = ~be[1] during ACC1 and ACC2.
REQ-028 SHALL treat be=2'b00 as a full cycle with no lane enabled, and still acknowledge it.
REQ-029 SHALL pulse ack_o for the granted port in the cycle after ACC2; the access latency from grant is 3 clocks.
REQ-030 SHALL go from ACC2 to VID if the counter wraps to 0, and otherwise to IDLE.
REQ-031 SHALL ignore the acked port's req_i for arbitration in its ack cycle; other ports may be granted in that cycle.
REQ-032 SHALL, when idle and outside VID: ram_oe_n=1, ram_we_n=1, lanes high, ram_dq_oe=0, ram_addr holds its last value.

Reset
REQ-033 SHALL, in the cycle after reset_in is sampled high, set:
- state IDLE and counter 0;
- ack_o=0, vid_valid_o=0, rdata_o=0, vid_data_o=0, ram_addr=0;
- ram_we_n=1, ram_oe_n=1, ram_lb_n=1, ram_ub_n=1, ram_dq_oe=0.
REQ-034 SHALL, on reset mid-access, abort the transaction without issuing ack_o, and the round-robin pointer SHALL return to port 0.

Configuration
REQ-035 SHALL provide macro MEM_ARB_ROUND_ROBIN_EN:
- Defined: rotating priority; the port granted last is lowest at the next arbitration.
- Undefined: fixed priority; the lowest index wins.

Verification
REQ-036 SHALL cover single read: port1 reads addr 0x01234 requested at counter 2, model returns 0xBEEF -> ACC1 at 3, ack_o=3'b010 at 5, rdata_o=0xBEEF.
REQ-037 SHALL cover the video guard: port0 request raised at counter 14 -> no grant at 14, 15, 0 or 1; VID at 0-1; grant at 2; ack at 5.
REQ-038 SHALL cover contention: ports 0, 1 and 2 all request at counter 2 ->
- fixed priority: acks at counters 5, 8, 11 in order 0, 1, 2;
- with MEM_ARB_ROUND_ROBIN_EN and last grant = 1: order 2, 0, 1.
REQ-039 SHALL cover a byte write: port2 writes be=2'b10, addr 0x00100, data 0xA500 -> ram_we_n low exactly 1 cycle, ram_ub_n=0, ram_lb_n=1, ram_dq_o=0xA500.
REQ-040 SHALL cover reset during ACC1 of a write -> next cycle ram_we_n=1, ram_dq_oe=0, and no ack_o.
REQ-041 SHALL cover a video fetch: vid_addr_i=0x04000, model returns 0x5A5A -> vid_valid_o pulses at counter 2 with vid_data_o=0x5A5A, every 16 clocks.
